// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST sequencer: FSM states, the test
// pattern function and the error-counter width margin.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_RD0  = 3'd2,
    S_CHK0 = 3'd3,
    S_WR1  = 3'd4,
    S_RD1  = 3'd5,
    S_CHK1 = 3'd6,
    S_DONE = 3'd7
  } state_e;

  // err_count is A_WIDTH + ERR_EXTRA_BITS wide, so 2*N mismatches never saturate it.
  localparam int ERR_EXTRA_BITS = 2;

  // Callers zero-extend into and truncate out of this width.
  localparam int PAT_MAX_W = 64;

  function automatic logic [PAT_MAX_W-1:0] pattern_f(
    input logic [PAT_MAX_W-1:0] addr,
    input logic [PAT_MAX_W-1:0] seed,
    input logic                 inv
  );
    logic [PAT_MAX_W-1:0] p;
    p = addr ^ seed;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-data checker: one-stage expected-data pipeline, compare, saturating
// error counter and optional first-failure capture (RAM_BIST_CAPTURE_EN).
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int                 D_WIDTH = 16,
  parameter int                 A_WIDTH = 5,
  parameter logic [D_WIDTH-1:0] SEED    = D_WIDTH'(16'hA5C3),
  parameter int                 ERR_W   = A_WIDTH + ERR_EXTRA_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               rd_en,
  input  logic               rd_inv,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic [D_WIDTH-1:0] data_read,
  output logic [ERR_W-1:0]   err_count,
  output logic [A_WIDTH-1:0] first_fail_addr,
  output logic [D_WIDTH-1:0] first_fail_data
);

  logic               vld_q;
  logic [D_WIDTH-1:0] exp_q;
  logic [D_WIDTH-1:0] exp_d;
  logic [ERR_W-1:0]   err_q;
  logic               mismatch;

  assign exp_d    = D_WIDTH'(pattern_f(PAT_MAX_W'(rd_addr), PAT_MAX_W'(SEED), rd_inv));
  assign mismatch = vld_q && (data_read != exp_q);

  // The RAM returns data one cycle after the address, so the expectation rides along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      exp_q <= '0;
      err_q <= '0;
    end else if (clear) begin
      vld_q <= 1'b0;
      exp_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= rd_en;
      exp_q <= exp_d;
      if (mismatch && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;

`ifdef RAM_BIST_CAPTURE_EN
  logic [A_WIDTH-1:0] addr_q;
  logic [A_WIDTH-1:0] cap_addr_q;
  logic [D_WIDTH-1:0] cap_data_q;

  // err_q still zero means this is the first mismatch of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else if (clear) begin
      addr_q     <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else begin
      addr_q <= rd_addr;
      if (mismatch && (err_q == '0)) begin
        cap_addr_q <= addr_q;
        cap_data_q <= data_read;
      end
    end
  end

  assign first_fail_addr = cap_addr_q;
  assign first_fail_data = cap_data_q;
`else
  assign first_fail_addr = '0;
  assign first_fail_data = '0;
`endif

endmodule

// File: rtl/ram_bist.sv
// Two-pass (true / inverted pattern) write/read-back BIST sequencer for the
// dual-port RAM. Optional first-failure capture via RAM_BIST_CAPTURE_EN.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int                 D_WIDTH = 16,
  parameter int                 A_WIDTH = 5,
  parameter logic [D_WIDTH-1:0] SEED    = D_WIDTH'(16'hA5C3)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [A_WIDTH+ERR_EXTRA_BITS-1:0] err_count,
  output logic [A_WIDTH-1:0]                first_fail_addr,
  output logic [D_WIDTH-1:0]                first_fail_data,
  output logic [A_WIDTH-1:0]                address_write,
  output logic [D_WIDTH-1:0]                data_write,
  output logic                              write_enable,
  output logic [A_WIDTH-1:0]                address_read,
  input  logic [D_WIDTH-1:0]                data_read,
  output logic [2:0]                        dbg_state
);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic               start_acc;
  logic               last;
  logic               rd_en;
  logic               rd_inv;

  // start is a single-cycle request with no ready: it is taken only in IDLE or
  // DONE and silently dropped while busy; done then holds until the next taken start.
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last      = (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_d = S_WR0;
          cnt_d   = '0;
        end
      end
      // The counter wraps to zero on the last address, ready for the next sweep.
      S_WR0: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_RD0;
      end
      S_RD0: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_CHK0;
      end
      S_CHK0: state_d = S_WR1;
      S_WR1: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_RD1;
      end
      S_RD1: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_CHK1;
      end
      S_CHK1: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only state_q/cnt_q/err_count, so reset clears them at once.
  always_comb begin
    busy          = 1'b0;
    write_enable  = 1'b0;
    address_write = '0;
    data_write    = '0;
    address_read  = '0;
    rd_en         = 1'b0;
    rd_inv        = 1'b0;
    case (state_q)
      S_WR0, S_WR1: begin
        busy          = 1'b1;
        write_enable  = 1'b1;
        address_write = cnt_q;
        data_write    = D_WIDTH'(pattern_f(PAT_MAX_W'(cnt_q), PAT_MAX_W'(SEED),
                                           state_q == S_WR1));
      end
      S_RD0, S_RD1: begin
        busy         = 1'b1;
        address_read = cnt_q;
        rd_en        = 1'b1;
        rd_inv       = (state_q == S_RD1);
      end
      S_CHK0, S_CHK1: busy = 1'b1;
      default: ;
    endcase
    done = (state_q == S_DONE);
    pass = done && (err_count == '0);
  end

  assign dbg_state = state_q;

  ram_bist_checker #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH),
    .SEED    (SEED),
    .ERR_W   (A_WIDTH + ERR_EXTRA_BITS)
  ) u_checker (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (start_acc),
    .rd_en           (rd_en),
    .rd_inv          (rd_inv),
    .rd_addr         (cnt_q),
    .data_read       (data_read),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .first_fail_data (first_fail_data)
  );

endmodule
